rr_select_sequencer: RTL and testbench
======================================

Name: rr_select_sequencer

Overview:
- Upstream control stage for the 4-to-1 selector (inputs i0..i3, selects s0/s1); it generates the select pair that steers the selector.
- Arbitrates four request lines round-robin and drives the registered selects s1:s0 plus a one-hot grant.
- Each granted channel stays selected for a bounded hold window, or less if it ends early.
- Guarantees the selector sees stable selects for whole cycles and that no channel is starved.

Parameters:
- HOLD_CYCLES, 4, maximum cycles a granted channel keeps the select; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy HOLD_CYCLES <= 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; bit n corresponds to selector input i_n.
- done  input  1  consumer pulse that releases the current grant early.
- s0  output  1  select LSB to the selector, registered.
- s1  output  1  select MSB to the selector, registered.
- grant  output  4  one-hot grant matching s1:s0; all zeros when idle.
- valid  output  1  high while a grant is active.
- busy  output  1  high in the HOLD state; identical to valid.

Behaviour:
- Reset (sampled at a rising edge):
  - s1:s0=00, grant=0000, valid=0, state=IDLE, counter=0.
  - last_ptr=3, so the first search starts at channel 0.
  - A reset mid-HOLD aborts the grant on that edge; no partial state is retained.
- States: IDLE, HOLD. There is no separate arbitration cycle.
- Round-robin pick (combinational):
  - Search order is last_ptr+1, +2, +3, +4, modulo 4, wrapping 3->0.
  - The first set req bit wins, so the just-served channel has lowest priority.
- IDLE:
  - If req != 0 at edge t: register the winner into s1:s0 and grant, set valid=1, load counter=HOLD_CYCLES-1, enter HOLD.
  - Outputs change at edge t, so latency is one cycle from req sampled to valid.
  - If req == 0: stay in IDLE with all outputs at their reset values, except that s1:s0 holds its last value.
- HOLD, release condition at an edge: counter==0, OR done==1, OR req[cur]==0.
  - On release: last_ptr<=cur. Then:
    - If another pick exists, using the updated pointer, regrant in the same edge (back-to-back, no idle bubble).
    - Otherwise go to IDLE and set valid=0, grant=0000.
  - With no release: counter decrements by 1; selects and grant hold.
- Window length: a full-length grant keeps valid high for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: every grant lasts exactly one cycle, and the selects rotate each cycle while multiple requests are present.
- Single requester: when only cur is requesting at release, it is re-granted. valid stays high and the counter reloads.
- Simultaneous done and counter==0: treated as one release; no double advance.
- done in IDLE is ignored.
- Invariant: s1:s0 always encodes the set bit of grant while valid=1.

Decomposition:
- Shared package:
  - State encoding constants: ST_IDLE=1'b0, ST_HOLD=1'b1.
  - Channel count constant NCH=4.
  - Select-to-one-hot decode function, also reused by selector-side checkers.
- Sub-module rr_priority_pick: purely combinational.
  - Inputs: req[3:0], last_ptr[1:0].
  - Outputs: found, pick[1:0].
  - Instantiated once. The FSM, counter and registers stay in the top.

Test Plan:
- Reset, then req=0001 held, HOLD_CYCLES=4:
  - valid rises 1 cycle after req, s1:s0=00, grant=0001.
  - After 4 cycles the channel is re-granted (same select, valid stays 1).
- req=1111 held:
  - Select sequence 00,01,10,11,00 is observed.
  - Each value is held exactly 4 cycles; grant is always one-hot and matches.
- req=0101, done pulsed in the 2nd cycle of channel 0's grant:
  - The next edge switches to s1:s0=10, grant=0100.
  - That grant lasts a full 4 cycles.
- Granted channel 2 drops req mid-window while req[3]=0 and all others are 0:
  - The next edge gives valid=0, grant=0000, state IDLE.
  - A later req=1000 grants channel 3 (pointer = 2).
- Assert reset during HOLD on channel 1:
  - The same edge gives valid=0, s1:s0=00.
  - With req=0011 after reset, channel 0 is granted first.
- HOLD_CYCLES=1, req=1010:
  - Selects alternate 01,11,01,11 every cycle; valid is continuously 1.

Source files
------------

// File: rtl/rr_select_sequencer_pkg.sv
// Shared definitions for the round-robin select sequencer and selector-side checkers.
package rr_select_sequencer_pkg;

    // Number of selector channels (i0..i3).
    localparam int unsigned NCH = 4;

    // Sequencer state encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Decode a 2-bit select into the matching one-hot grant vector.
    function automatic logic [NCH-1:0] sel_to_onehot(input logic [1:0] sel);
        logic [NCH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_select_sequencer_pick.sv
// Combinational round-robin picker: searches last_ptr+1 .. last_ptr+4 (mod 4) for a set request.
module rr_priority_pick
    import rr_select_sequencer_pkg::*;
(
    input  logic [NCH-1:0] req_i,
    input  logic [1:0]     last_ptr_i,
    output logic           found_o,
    output logic [1:0]     pick_o
);

    // First set bit after last_ptr wins; last_ptr itself is checked last.
    always_comb begin
        logic [1:0] idx;
        found_o = 1'b0;
        pick_o  = 2'd0;
        idx     = 2'd0;
        for (int i = 1; i <= NCH; i++) begin
            idx = last_ptr_i + 2'(i);
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                pick_o  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_select_sequencer.sv
// Round-robin select sequencer: drives registered s1:s0 and a one-hot grant for the 4-to-1 selector,
// holding each grant for at most HOLD_CYCLES cycles.
module rr_select_sequencer
    import rr_select_sequencer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic           done,
    output logic           s0,
    output logic           s1,
    output logic [NCH-1:0] grant,
    output logic           valid,
    output logic           busy
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_ptr_q, last_ptr_d;

    logic       found;
    logic [1:0] pick;
    logic [1:0] pick_ptr;
    logic       release_grant;

    // In HOLD the pick is only used on release, where the pointer becomes the current channel;
    // feeding sel_q directly lets the back-to-back regrant see the updated pointer.
    assign pick_ptr = (state_q == ST_HOLD) ? sel_q : last_ptr_q;

    rr_priority_pick u_pick (
        .req_i      (req),
        .last_ptr_i (pick_ptr),
        .found_o    (found),
        .pick_o     (pick)
    );

    // A single release covers any combination of window expiry, done and request drop.
    assign release_grant = (cnt_q == '0) || done || !req[sel_q];

    // Next-state logic: grant from IDLE, hold/decrement or release/regrant in HOLD.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        last_ptr_d = last_ptr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    grant_d = sel_to_onehot(pick);
                    cnt_d   = CntLoad;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (release_grant) begin
                    last_ptr_d = sel_q;
                    if (found) begin
                        sel_d   = pick;
                        grant_d = sel_to_onehot(pick);
                        cnt_d   = CntLoad;
                    end else begin
                        // Selects keep their last value while idle.
                        grant_d = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset; pointer resets to 3 so channel 0 is first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd0;
            grant_q    <= '0;
            cnt_q      <= '0;
            last_ptr_q <= 2'd3;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    assign s0    = sel_q[0];
    assign s1    = sel_q[1];
    assign grant = grant_q;
    assign valid = (state_q == ST_HOLD);
    assign busy  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_rr_select_sequencer.sv
// Directed self-checking bench for rr_select_sequencer (HOLD_CYCLES=4 and HOLD_CYCLES=1 instances).
module tb_rr_select_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;

    logic       s0, s1, valid, busy;
    logic [3:0] grant;
    logic       s0b, s1b, validb, busyb;
    logic [3:0] grantb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_select_sequencer #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .done  (done),
        .s0    (s0),
        .s1    (s1),
        .grant (grant),
        .valid (valid),
        .busy  (busy)
    );

    rr_select_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .done  (done),
        .s0    (s0b),
        .s1    (s1b),
        .grant (grantb),
        .valid (validb),
        .busy  (busyb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Compare select, grant and valid of the HOLD_CYCLES=4 instance.
    task automatic check_main(input string tag, input logic [1:0] sel, input logic [3:0] g,
                              input logic v);
        check_eq({tag, "_sel"}, {30'd0, s1, s0}, {30'd0, sel});
        check_eq({tag, "_grant"}, {28'd0, grant}, {28'd0, g});
        check_eq({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
    endtask

    initial begin
        // Reset state.
        do_reset();
        check_main("reset", 2'b00, 4'b0000, 1'b0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);

        // Single requester on channel 0: granted one edge later, re-granted after 4 cycles.
        req = 4'b0001;
        tick();
        check_main("single_first", 2'b00, 4'b0001, 1'b1);
        check_eq("single_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_main($sformatf("single_c%0d", i), 2'b00, 4'b0001, 1'b1);
        end

        // All four requesting: 00,01,10,11,00 each held exactly 4 cycles.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            logic [1:0] es;
            logic [3:0] eg;
            es = 2'((k / 4) % 4);
            eg = 4'b0001 << es;
            tick();
            check_main($sformatf("rr_k%0d", k), es, eg, 1'b1);
        end

        // done in the 2nd cycle of channel 0's grant moves to channel 2, which runs a full window.
        do_reset();
        req = 4'b0101;
        tick();
        check_main("done_c1", 2'b00, 4'b0001, 1'b1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_main("done_sw", 2'b10, 4'b0100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_main($sformatf("done_hold%0d", i), 2'b10, 4'b0100, 1'b1);
        end
        tick();
        check_main("done_back0", 2'b00, 4'b0001, 1'b1);

        // Channel 2 drops its request mid-window with nobody else requesting.
        do_reset();
        req = 4'b0100;
        tick();
        check_main("drop_grant", 2'b10, 4'b0100, 1'b1);
        tick();
        req = 4'b0000;
        tick();
        check_main("drop_idle", 2'b10, 4'b0000, 1'b0);
        // done while idle is ignored.
        done = 1'b1;
        tick();
        done = 1'b0;
        check_main("idle_done", 2'b10, 4'b0000, 1'b0);
        // Pointer is now 2, so channel 3 beats channel 0.
        req = 4'b1001;
        tick();
        check_main("ptr2_pick3", 2'b11, 4'b1000, 1'b1);

        // Reset during a channel 1 grant aborts it on that edge.
        do_reset();
        req = 4'b0010;
        tick();
        check_main("rst_pre", 2'b01, 4'b0010, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check_main("rst_mid", 2'b00, 4'b0000, 1'b0);
        reset = 1'b0;
        req   = 4'b0011;
        tick();
        check_main("rst_after", 2'b00, 4'b0001, 1'b1);

        // HOLD_CYCLES=1: selects alternate 01,11 every cycle with valid continuously high.
        do_reset();
        req = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] es;
            es = (k % 2 == 0) ? 2'b01 : 2'b11;
            tick();
            check_eq($sformatf("h1_sel%0d", k), {30'd0, s1b, s0b}, {30'd0, es});
            check_eq($sformatf("h1_grant%0d", k), {28'd0, grantb}, {28'd0, 4'b0001 << es});
            check_eq($sformatf("h1_valid%0d", k), {31'd0, validb}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
